// File: rtl/discharge_pkg.sv
// Shared constants for the discharge parameter bank: parameter indices,
// waveform codes and default reset/limit vectors (index 0 in the LSBs).
package discharge_pkg;

   typedef logic [15:0] param_word_t;

   localparam int IDX_TON      = 0;
   localparam int IDX_TOFF     = 1;
   localparam int IDX_IP       = 2;
   localparam int IDX_WAVEFORM = 3;

   localparam param_word_t WAVE_RES  = 16'h8000;
   localparam param_word_t WAVE_RECT = 16'h0001;
   localparam param_word_t WAVE_TRI  = 16'h0002;

   localparam logic [63:0] DEF_PARAM_RST = {16'h0001, 16'd20, 16'd100, 16'd20};
   localparam logic [63:0] DEF_PARAM_MIN = {16'h0000, 16'd1, 16'd1, 16'd1};
   localparam logic [63:0] DEF_PARAM_MAX = {16'hFFFF, 16'd78, 16'd10000, 16'd1000};

endpackage

// File: rtl/discharge_param_bank_if.sv
// Command/parameter bus between SPI/key logic, mos_control and the parameter bank.
interface discharge_param_bank_if #(
   parameter int NUM_SRC   = 2,
   parameter int NUM_PARAM = 4,
   parameter int DATA_W    = 16
);
   logic [NUM_SRC-1:0]          start_ack;
   logic [NUM_SRC-1:0]          stop_ack;
   logic [NUM_PARAM-1:0]        change_ack;
   logic [NUM_PARAM*DATA_W-1:0] param_data_async;
   logic                        cycle_boundary;
   logic [NUM_PARAM*DATA_W-1:0] param_active;
   logic [NUM_PARAM-1:0]        param_pending;
   logic                        param_update;
   logic                        is_machine;
   logic [NUM_PARAM-1:0]        clamp_flag;

   modport master (
      output start_ack, stop_ack, change_ack, param_data_async, cycle_boundary,
      input  param_active, param_pending, param_update, is_machine, clamp_flag
   );

   modport slave (
      input  start_ack, stop_ack, change_ack, param_data_async, cycle_boundary,
      output param_active, param_pending, param_update, is_machine, clamp_flag
   );
endinterface

// File: rtl/param_sync_capture.sv
// One parameter lane: change strobe synchroniser, rising-edge detect, optional
// range clamp (DISCHARGE_PARAM_CLAMP_EN) and the shadow/pending register.
module param_sync_capture #(
   parameter int              DATA_W      = 16,
   parameter int              SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] RST_VAL   = '0,
   parameter logic [DATA_W-1:0] MIN_VAL   = '0,
   parameter logic [DATA_W-1:0] MAX_VAL   = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              change_ack,
   input  logic [DATA_W-1:0] data_in,
   input  logic              commit,
   output logic [DATA_W-1:0] shadow,
   output logic              pending,
   output logic              clamp_flag
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic                   edge_r;
   logic [DATA_W-1:0]      shadow_r;
   logic                   pending_r;
   logic [DATA_W-1:0]      captured_s;

   // Synchronise the strobe and register a one-cycle pulse on its rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
         prev_r <= 1'b0;
         edge_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], change_ack};
         prev_r <= sync_r[SYNC_STAGES-1];
         edge_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
      end
   end

`ifdef DISCHARGE_PARAM_CLAMP_EN
   logic [DATA_W:0] below_diff_s;
   logic [DATA_W:0] above_diff_s;
   logic            clamp_hit_s;
   logic            clamp_flag_r;

   // Borrow bits give unsigned compares that stay well-formed when a limit is zero
   assign below_diff_s = {1'b0, data_in} - {1'b0, MIN_VAL};
   assign above_diff_s = {1'b0, MAX_VAL} - {1'b0, data_in};

   // Range clamp of the incoming value
   always_comb begin
      captured_s  = data_in;
      clamp_hit_s = 1'b0;
      if (below_diff_s[DATA_W]) begin
         captured_s  = MIN_VAL;
         clamp_hit_s = 1'b1;
      end else if (above_diff_s[DATA_W]) begin
         captured_s  = MAX_VAL;
         clamp_hit_s = 1'b1;
      end else begin
         captured_s  = data_in;
         clamp_hit_s = 1'b0;
      end
   end

   // Sticky clamp indication, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clamp_flag_r <= 1'b0;
      end else if (edge_r && clamp_hit_s) begin
         clamp_flag_r <= 1'b1;
      end
   end

   assign clamp_flag = clamp_flag_r;
`else
   assign captured_s = data_in;
   assign clamp_flag = 1'b0;
`endif

   // A capture wins over a same-cycle commit so the newer value stays pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_r  <= RST_VAL;
         pending_r <= 1'b0;
      end else if (edge_r) begin
         shadow_r  <= captured_s;
         pending_r <= 1'b1;
      end else if (commit) begin
         pending_r <= 1'b0;
      end
   end

   assign shadow  = shadow_r;
   assign pending = pending_r;

endmodule

// File: rtl/discharge_param_bank.sv
// Discharge parameter bank: merges start/stop sources into is_machine and
// commits captured parameters atomically. Clamp option: DISCHARGE_PARAM_CLAMP_EN.
module discharge_param_bank
   import discharge_pkg::*;
#(
   parameter int                          NUM_SRC     = 2,
   parameter int                          NUM_PARAM   = 4,
   parameter int                          DATA_W      = 16,
   parameter int                          SYNC_STAGES = 2,
   parameter logic [NUM_SRC-1:0]          SRC_ASYNC   = 2'b01,
   parameter logic [NUM_SRC-1:0]          SRC_RST_EN  = 2'b10,
   parameter logic [NUM_PARAM*DATA_W-1:0] PARAM_RST   = DEF_PARAM_RST,
   parameter logic [NUM_PARAM*DATA_W-1:0] PARAM_MIN   = DEF_PARAM_MIN,
   parameter logic [NUM_PARAM*DATA_W-1:0] PARAM_MAX   = DEF_PARAM_MAX
) (
   input  logic                  clk,
   input  logic                  rst_n,
   discharge_param_bank_if.slave bus
);

   logic [NUM_SRC-1:0]          start_s;
   logic [NUM_SRC-1:0]          stop_s;
   logic [NUM_SRC-1:0]          enable_r;
   logic [NUM_SRC-1:0]          enable_next_s;
   logic                        machine_r;
   logic [NUM_PARAM-1:0]        pending_s;
   logic [NUM_PARAM-1:0]        clamp_s;
   logic [NUM_PARAM*DATA_W-1:0] shadow_s;
   logic [NUM_PARAM*DATA_W-1:0] active_r;
   logic                        update_r;
   logic                        commit_s;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      if (SRC_ASYNC[i]) begin : g_async
         logic [SYNC_STAGES-1:0] start_sync_r;
         logic [SYNC_STAGES-1:0] stop_sync_r;

         // Synchronise start/stop requests from an asynchronous source
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               start_sync_r <= '0;
               stop_sync_r  <= '0;
            end else begin
               start_sync_r <= {start_sync_r[SYNC_STAGES-2:0], bus.start_ack[i]};
               stop_sync_r  <= {stop_sync_r[SYNC_STAGES-2:0], bus.stop_ack[i]};
            end
         end

         assign start_s[i] = start_sync_r[SYNC_STAGES-1];
         assign stop_s[i]  = stop_sync_r[SYNC_STAGES-1];
      end else begin : g_sync
         assign start_s[i] = bus.start_ack[i];
         assign stop_s[i]  = bus.stop_ack[i];
      end
   end

   // Per-source enable update; stop has priority over start
   always_comb begin
      enable_next_s = enable_r;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (stop_s[i]) begin
            enable_next_s[i] = 1'b0;
         end else if (start_s[i]) begin
            enable_next_s[i] = 1'b1;
         end else begin
            enable_next_s[i] = enable_r[i];
         end
      end
   end

   // Source enables and the registered machine-running flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_r  <= SRC_RST_EN;
         machine_r <= &SRC_RST_EN;
      end else begin
         enable_r  <= enable_next_s;
         machine_r <= &enable_r;
      end
   end

   for (genvar k = 0; k < NUM_PARAM; k++) begin : g_param
      param_sync_capture #(
         .DATA_W      (DATA_W),
         .SYNC_STAGES (SYNC_STAGES),
         .RST_VAL     (PARAM_RST[k*DATA_W +: DATA_W]),
         .MIN_VAL     (PARAM_MIN[k*DATA_W +: DATA_W]),
         .MAX_VAL     (PARAM_MAX[k*DATA_W +: DATA_W])
      ) u_capture (
         .clk        (clk),
         .rst_n      (rst_n),
         .change_ack (bus.change_ack[k]),
         .data_in    (bus.param_data_async[k*DATA_W +: DATA_W]),
         .commit     (commit_s),
         .shadow     (shadow_s[k*DATA_W +: DATA_W]),
         .pending    (pending_s[k]),
         .clamp_flag (clamp_s[k])
      );
   end

   assign commit_s = (bus.cycle_boundary || !machine_r) && (|pending_s);

   // Atomic commit of every pending shadow into the active set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_r <= PARAM_RST;
         update_r <= 1'b0;
      end else begin
         update_r <= commit_s;
         for (int k = 0; k < NUM_PARAM; k++) begin
            if (commit_s && pending_s[k]) begin
               active_r[k*DATA_W +: DATA_W] <= shadow_s[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign bus.param_active  = active_r;
   assign bus.param_pending = pending_s;
   assign bus.param_update  = update_r;
   assign bus.is_machine    = machine_r;
   assign bus.clamp_flag    = clamp_s;

endmodule

// File: tb/tb_discharge_param_bank.sv
// Directed self-checking bench for discharge_param_bank (default parameters);
// expectations follow DISCHARGE_PARAM_CLAMP_EN when it is defined.
module tb_discharge_param_bank;

   localparam logic [63:0] RST_ACTIVE = {16'd1, 16'd20, 16'd100, 16'd20};
`ifdef DISCHARGE_PARAM_CLAMP_EN
   localparam logic [15:0] IP_EXP    = 16'd78;
   localparam logic [3:0]  CLAMP_EXP = 4'b0100;
`else
   localparam logic [15:0] IP_EXP    = 16'd120;
   localparam logic [3:0]  CLAMP_EXP = 4'b0000;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   discharge_param_bank_if #(.NUM_SRC(2), .NUM_PARAM(4), .DATA_W(16)) bus ();

   discharge_param_bank dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic boundary_pulse();
      bus.cycle_boundary = 1'b1;
      tick(1);
      bus.cycle_boundary = 1'b0;
   endtask

   initial begin
      rst_n                = 1'b0;
      bus.start_ack        = 2'b00;
      bus.stop_ack         = 2'b00;
      bus.change_ack       = 4'b0000;
      bus.param_data_async = 64'd0;
      bus.cycle_boundary   = 1'b0;
      #12;
      check("rst_active", bus.param_active, RST_ACTIVE);
      check("rst_pending", bus.param_pending, 4'b0000);
      check("rst_update", bus.param_update, 1'b0);
      check("rst_machine", bus.is_machine, 1'b0);
      check("rst_clamp", bus.clamp_flag, 4'b0000);
      tick(1);
      rst_n = 1'b1;
      tick(3);
      check("idle_active", bus.param_active, RST_ACTIVE);
      check("idle_machine", bus.is_machine, 1'b0);

      // async start on source 0: is_machine at edge 4
      bus.start_ack = 2'b01;
      tick(1);
      bus.start_ack = 2'b00;
      tick(2);
      check("start_e3", bus.is_machine, 1'b0);
      tick(1);
      check("start_e4", bus.is_machine, 1'b1);

      // synchronous key source stop/start: two edges
      bus.stop_ack = 2'b10;
      tick(1);
      bus.stop_ack = 2'b00;
      check("keystop_e1", bus.is_machine, 1'b1);
      tick(1);
      check("keystop_e2", bus.is_machine, 1'b0);
      bus.start_ack = 2'b10;
      tick(1);
      bus.start_ack = 2'b00;
      tick(1);
      check("keystart_e2", bus.is_machine, 1'b1);

      // async stop
      bus.stop_ack = 2'b01;
      tick(1);
      bus.stop_ack = 2'b00;
      tick(2);
      check("stop_e3", bus.is_machine, 1'b1);
      tick(1);
      check("stop_e4", bus.is_machine, 1'b0);

      // start and stop together: stop wins
      bus.start_ack = 2'b01;
      bus.stop_ack  = 2'b01;
      tick(1);
      bus.start_ack = 2'b00;
      bus.stop_ack  = 2'b00;
      tick(5);
      check("startstop", bus.is_machine, 1'b0);

      // machine stopped: Ip = 50 pending at edge 4, committed at edge 5
      bus.param_data_async[47:32] = 16'd50;
      bus.change_ack = 4'b0100;
      tick(3);
      check("ip_pend_e3", bus.param_pending, 4'b0000);
      tick(1);
      check("ip_pend_e4", bus.param_pending, 4'b0100);
      check("ip_act_e4", bus.param_active, RST_ACTIVE);
      check("ip_upd_e4", bus.param_update, 1'b0);
      tick(1);
      check("ip_pend_e5", bus.param_pending, 4'b0000);
      check("ip_act_e5", bus.param_active, {16'd1, 16'd50, 16'd100, 16'd20});
      check("ip_upd_e5", bus.param_update, 1'b1);
      tick(1);
      check("ip_upd_e6", bus.param_update, 1'b0);
      tick(3);
      check("ip_hold_once", bus.param_pending, 4'b0000);
      check("ip_hold_upd", bus.param_update, 1'b0);
      bus.change_ack = 4'b0000;
      tick(3);

      // machine running: Ton = 300 waits for the boundary
      bus.start_ack = 2'b01;
      tick(1);
      bus.start_ack = 2'b00;
      tick(4);
      check("run_machine", bus.is_machine, 1'b1);
      bus.param_data_async[15:0] = 16'd300;
      bus.change_ack = 4'b0001;
      tick(4);
      check("ton_pend", bus.param_pending, 4'b0001);
      tick(3);
      check("ton_wait_act", bus.param_active, {16'd1, 16'd50, 16'd100, 16'd20});
      check("ton_wait_upd", bus.param_update, 1'b0);
      bus.change_ack = 4'b0000;
      boundary_pulse();
      check("ton_commit_act", bus.param_active, {16'd1, 16'd50, 16'd100, 16'd300});
      check("ton_commit_upd", bus.param_update, 1'b1);
      check("ton_commit_pend", bus.param_pending, 4'b0000);
      tick(1);
      check("ton_upd_once", bus.param_update, 1'b0);
      boundary_pulse();
      check("bnd_nopend_upd", bus.param_update, 1'b0);

      // Ip = 120 above the upper limit
      bus.param_data_async[47:32] = 16'd120;
      bus.change_ack = 4'b0100;
      tick(4);
      bus.change_ack = 4'b0000;
      check("clamp_pend", bus.param_pending, 4'b0100);
      check("clamp_flag", bus.clamp_flag, CLAMP_EXP);
      boundary_pulse();
      check("clamp_act", bus.param_active, {16'd1, IP_EXP, 16'd100, 16'd300});

      // Ton 350 and Toff 500 pending, then Ton 400 captured on a boundary
      bus.param_data_async[15:0] = 16'd350;
      bus.change_ack = 4'b0001;
      tick(4);
      bus.change_ack = 4'b0000;
      check("mix_ton_pend", bus.param_pending, 4'b0001);
      bus.param_data_async[31:16] = 16'd500;
      bus.change_ack = 4'b0010;
      tick(4);
      bus.change_ack = 4'b0000;
      check("mix_both_pend", bus.param_pending, 4'b0011);
      tick(2);
      bus.param_data_async[15:0] = 16'd400;
      bus.change_ack = 4'b0001;
      tick(3);
      boundary_pulse();
      check("mix_act", bus.param_active, {16'd1, IP_EXP, 16'd500, 16'd350});
      check("mix_pend", bus.param_pending, 4'b0001);
      check("mix_upd", bus.param_update, 1'b1);
      bus.change_ack = 4'b0000;
      tick(2);
      check("mix_hold_act", bus.param_active, {16'd1, IP_EXP, 16'd500, 16'd350});
      check("mix_hold_pend", bus.param_pending, 4'b0001);
      boundary_pulse();
      check("mix2_act", bus.param_active, {16'd1, IP_EXP, 16'd500, 16'd400});
      check("mix2_pend", bus.param_pending, 4'b0000);

      // reset mid-transfer discards the pending Toff
      bus.param_data_async[31:16] = 16'd7;
      bus.change_ack = 4'b0010;
      tick(4);
      check("mid_pend", bus.param_pending, 4'b0010);
      rst_n = 1'b0;
      #2;
      check("mid_rst_act", bus.param_active, RST_ACTIVE);
      check("mid_rst_pend", bus.param_pending, 4'b0000);
      check("mid_rst_machine", bus.is_machine, 1'b0);
      check("mid_rst_clamp", bus.clamp_flag, 4'b0000);
      bus.change_ack = 4'b0000;
      tick(1);
      rst_n = 1'b1;
      tick(6);
      check("post_rst_act", bus.param_active, RST_ACTIVE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/discharge_param_bank.md
Name: discharge_param_bank

Overview:
- Generalised successor to the discharge-control front end.
- Merges NUM_SRC machine start/stop command sources into one registered is_machine.
- Captures NUM_PARAM asynchronous discharge parameters (Ton, Toff, Ip, waveform, ...) into shadow registers and range-clamps them.
- Commits all pending parameters atomically to the active set only at a discharge-cycle boundary or while the machine is stopped. Sits between the SPI/key command logic and mos_control.

Parameters:
- NUM_SRC, 2: number of start/stop command sources. Bit0 = SPI, bit1 = key.
- NUM_PARAM, 4: number of parameters. Index 0 Ton, 1 Toff, 2 Ip, 3 waveform.
- DATA_W, 16: width of each parameter.
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- SRC_ASYNC, 2'b01: per-source flag; 1 = start/stop acks pass through the synchroniser.
- SRC_RST_EN, 2'b10: per-source enable value at reset.
- PARAM_RST, {16'h0001,16'd20,16'd100,16'd20}: reset/active value per parameter, index 0 in the LSBs.
- PARAM_MIN, {16'h0000,16'd1,16'd1,16'd1}: lower clamp limit per parameter.
- PARAM_MAX, {16'hFFFF,16'd78,16'd10000,16'd1000}: upper clamp limit per parameter.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_ack  in  NUM_SRC  per-source start request, level or pulse.
- stop_ack  in  NUM_SRC  per-source stop request.
- change_ack  in  NUM_PARAM  per-parameter change strobe, asynchronous.
- param_data_async  in  NUM_PARAM*DATA_W  new values. Each value is held stable while its change_ack is high.
- cycle_boundary  in  1  one-clk pulse from mos_control when no discharge pulse is in progress.
- param_active  out  NUM_PARAM*DATA_W  committed parameters, fed to mos_control.
- param_pending  out  NUM_PARAM  shadow value is newer than the active value.
- param_update  out  1  one-clk pulse on the cycle a commit took effect.
- is_machine  out  1  AND of all source enables, registered.
- clamp_flag  out  NUM_PARAM  sticky; set when a captured value was clamped.

Behaviour:
- Reset, asynchronous:
  - param_active = shadow = PARAM_RST.
  - param_pending = 0, param_update = 0, clamp_flag = 0.
  - Source enables = SRC_RST_EN; is_machine = &SRC_RST_EN.
  - Synchroniser and edge-detect registers cleared.
  - A reset mid-transfer discards the shadow and pending state.
- Source enable, per source i:
  - If SRC_ASYNC[i] is set, start_ack and stop_ack pass through SYNC_STAGES flops first.
  - The enable is set when start is high and cleared when stop is high.
  - Start and stop high in the same cycle: stop wins.
  - is_machine is registered from the AND of the enables, giving one extra cycle of latency.
- Parameter capture, per parameter k:
  - change_ack[k] passes through SYNC_STAGES flops, then a rising-edge detect.
  - On the detected edge, shadow[k] is loaded with the clamped param_data_async[k] and pending[k] is set.
  - Latency: counting the first clk edge that samples ack high as edge 1, shadow and pending update on edge SYNC_STAGES+2.
  - Holding ack high captures only once; a new capture requires ack to return low first.
- Clamping:
  - Unsigned compare.
  - Value < MIN → MIN; value > MAX → MAX; otherwise the value unchanged.
  - Any clamp sets clamp_flag[k]. The flag is cleared only by reset.
- Commit condition: (cycle_boundary || !is_machine) && |param_pending.
  - On commit, every pending index copies shadow to active and clears its pending bit.
  - Non-pending indices are unchanged.
  - param_update is registered high for exactly one cycle, aligned with the new param_active.
- Capture and commit in the same cycle for the same k: active takes the old shadow, the new value goes into shadow, and pending[k] stays 1.
- Machine stopped: a commit occurs on the cycle after pending is set.
- cycle_boundary with no pending bits: no commit and no param_update pulse.

Optional Feature:
- Macro: DISCHARGE_PARAM_CLAMP_EN.
- Defined: the clamping behaviour above applies.
- Undefined: captured values pass through unmodified; clamp_flag is tied to 0; PARAM_MIN and PARAM_MAX are unused.

Decomposition:
- Shared package discharge_pkg holds:
  - Index constants IDX_TON = 0, IDX_TOFF = 1, IDX_IP = 2, IDX_WAVEFORM = 3.
  - Waveform codes WAVE_RES = 16'h8000, WAVE_RECT = 16'h0001, WAVE_TRI = 16'h0002.
  - Default limit constants.
- Sub-module param_sync_capture: synchroniser, edge detect, clamp and shadow/pending for one parameter. Instantiated NUM_PARAM times in a generate loop.
- The top level holds the source-enable logic and the atomic commit.

Test Plan:
- Reset then idle → param_active = {1,20,100,20}, is_machine = 0 with default SRC_RST_EN, all flags 0.
- start_ack[0] pulse (async source) → is_machine = 1 at edge SYNC_STAGES+2. start_ack[0] and stop_ack[0] together → enable 0, is_machine stays 0.
- is_machine = 0; change_ack[IDX_IP] with data 50 → pending[2] set at edge 4; param_active Ip = 50 and param_update pulse at edge 5.
- is_machine = 1; write Ton = 300 → active Ton stays 20 until the cycle_boundary pulse, then becomes 300 with one param_update.
- Write Ip = 120 with the macro defined → Ip = 78, clamp_flag[2] = 1. Without the macro → Ip = 120, clamp_flag = 0.
- Ton capture coincides with cycle_boundary while Toff is pending → Toff and old Ton shadow committed; new Ton stays pending until the next boundary.
